// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle SRAM between the IF and MEM pipeline ports, freezing the pipeline until both are served.
// Optional freeze-cycle performance counter enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
   parameter int WAIT_CYCLES = 4,
   parameter int AW          = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [31:0]   if_rdata,
   output logic          if_ready,
   input  logic          mem_r_en,
   input  logic          mem_w_en,
   input  logic [AW-1:0] mem_addr,
   input  logic [31:0]   mem_wdata,
   output logic [31:0]   mem_rdata,
   output logic          mem_ready,
   output logic          freeze,
   output logic [AW-3:0] sram_addr,
   output logic [31:0]   sram_wdata,
   output logic          sram_we,
   output logic          sram_en,
   input  logic [31:0]   sram_rdata,
   output logic [31:0]   freeze_cycles
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RECOVER = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t     state;
   state_t     state_next;
   logic [3:0] wait_cnt;
   logic       if_done;
   logic       mem_done;
   logic       gnt_mem;
   logic       mem_req;
   logic       if_pending;
   logic       mem_pending;
   logic       grant;
   logic       grant_mem;
   logic       access_last;
   logic       unused_addr_bits;

   assign mem_req          = mem_r_en | mem_w_en;
   assign if_pending       = if_req & ~if_done;
   assign mem_pending      = mem_req & ~mem_done;
   assign freeze           = if_pending | mem_pending;
   assign if_ready         = if_done;
   assign mem_ready        = mem_done;
   assign unused_addr_bits = ^{if_addr[1:0], mem_addr[1:0]};

   // Next-state and grant decision; MEM holds the older instruction so it wins ties.
   always_comb begin
      state_next  = state;
      grant       = 1'b0;
      grant_mem   = 1'b0;
      access_last = 1'b0;
      case (state)
         IDLE: begin
            if (mem_pending) begin
               grant      = 1'b1;
               grant_mem  = 1'b1;
               state_next = ACCESS;
            end else if (if_pending) begin
               grant      = 1'b1;
               state_next = ACCESS;
            end else begin
               state_next = IDLE;
            end
         end
         ACCESS: begin
            if (wait_cnt == 4'd0) begin
               access_last = 1'b1;
               state_next  = RECOVER;
            end else begin
               state_next  = ACCESS;
            end
         end
         RECOVER: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State, SRAM port, wait counter, read-data capture and served flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         gnt_mem    <= 1'b0;
         if_done    <= 1'b0;
         mem_done   <= 1'b0;
         sram_en    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= 32'd0;
         if_rdata   <= 32'd0;
         mem_rdata  <= 32'd0;
      end else begin
         state <= state_next;
         if (grant) begin
            sram_en    <= 1'b1;
            sram_we    <= grant_mem & mem_w_en;
            sram_addr  <= grant_mem ? mem_addr[AW-1:2] : if_addr[AW-1:2];
            sram_wdata <= grant_mem ? mem_wdata : 32'd0;
            wait_cnt   <= WAIT_LOAD;
            gnt_mem    <= grant_mem;
         end else if (access_last) begin
            sram_en <= 1'b0;
            sram_we <= 1'b0;
         end else if (state == ACCESS) begin
            wait_cnt <= wait_cnt - 4'd1;
         end else begin
            sram_en <= 1'b0;
            sram_we <= 1'b0;
         end

         if (access_last && !sram_we) begin
            if (gnt_mem) begin
               mem_rdata <= sram_rdata;
            end else begin
               if_rdata <= sram_rdata;
            end
         end else begin
            mem_rdata <= mem_rdata;
         end

         // Served flags survive until the pipeline actually advances.
         if (!freeze) begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
         end else if (access_last) begin
            if (gnt_mem) begin
               mem_done <= 1'b1;
            end else begin
               if_done <= 1'b1;
            end
         end else begin
            if_done <= if_done;
         end
      end
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_cnt;

   // Saturating count of frozen cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cnt <= 32'd0;
      end else if (freeze && (perf_cnt != 32'hFFFF_FFFF)) begin
         perf_cnt <= perf_cnt + 32'd1;
      end else begin
         perf_cnt <= perf_cnt;
      end
   end

   assign freeze_cycles = perf_cnt;
`else
   assign freeze_cycles = 32'd0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-port, multi-cycle external SRAM between the instruction-fetch port (IF stage) and the data-memory port (MEM stage) of the 5-stage MIPS pipeline. It sequences each access through a wait-state FSM, holds returned read data, and drives a global `freeze` that stalls every pipeline register until all pending accesses of the current pipeline cycle have completed.

## Interface
- `WAIT_CYCLES`, 4: SRAM cycles per access; legal range 1..15.
- `AW`, 32: address width (byte address; SRAM receives `addr[AW-1:2]`).
- `clk  in  1`: rising-edge clock.
- `rst  in  1`: synchronous, active-high reset.
- `if_req  in  1`: IF stage requests an instruction read.
- `if_addr  in  AW`: fetch address; stable while `if_req` is high and `freeze` is high.
- `if_rdata  out  32`: fetched word; valid while `if_ready` is high.
- `if_ready  out  1`: IF access served for the current pipeline cycle.
- `mem_r_en`, `mem_w_en`  in  1 each: MEM stage load / store.
- `mem_addr  in  AW`, `mem_wdata  in  32`: data access address and store data.
- `mem_rdata  out  32`: load data; valid while `mem_ready` is high.
- `mem_ready  out  1`: MEM access served for the current pipeline cycle.
- `freeze  out  1`: stalls all pipeline registers when high.
- `sram_addr  out  AW-2`, `sram_wdata  out  32`, `sram_we  out  1`, `sram_en  out  1`: SRAM port, all registered.
- `sram_rdata  in  32`: SRAM read data.
- `freeze_cycles  out  32`: performance counter (see Configuration).

## Operation
- States: IDLE, ACCESS, RECOVER. Reset state is IDLE.
- Requester is pending when `mem_req = mem_r_en | mem_w_en` (or `if_req`) is high and its done flag is clear.
- IDLE: grant MEM if pending, else IF if pending, else stay. On grant, register SRAM signals, load wait counter with WAIT_CYCLES-1, and go to ACCESS. Fixed priority: MEM (older instruction) wins simultaneous requests.
- ACCESS: hold SRAM signals. Decrement the counter. At count 0:
  - capture `sram_rdata` into the granted requester's data register (reads only);
  - set that requester's done flag;
  - go to RECOVER.
- RECOVER: one bus-turnaround cycle with `sram_en=0`, `sram_we=0`, then go to IDLE.
- Store: `sram_we=1` for all WAIT_CYCLES cycles of ACCESS. `mem_rdata` is unchanged. If `mem_r_en` and `mem_w_en` are both high, the access is a store.
- `if_ready` = `if_done`; `mem_ready` = `mem_done`.
- `freeze = (if_req & ~if_done) | (mem_req & ~mem_done)`, combinational.
- Done flags clear on the first edge where `freeze=0`, i.e. when the pipeline advances. A served requester is never re-accessed while the pipeline remains frozen.
- Data registers hold their value until the next capture.

## Timing
- Reset values: state IDLE; done flags 0; `if_ready`, `mem_ready`, `sram_en`, `sram_we` = 0; `sram_addr`, `sram_wdata`, `if_rdata`, `mem_rdata`, `freeze_cycles` = 0.
- `freeze` follows the request inputs combinationally after reset: it is high in any cycle where a request is pending.
- Single access, request first seen in IDLE at cycle 0:
  - SRAM driven in cycles 1..WAIT_CYCLES;
  - ready high and `freeze` low in cycle WAIT_CYCLES+1 (RECOVER);
  - latency is WAIT_CYCLES+1.
- Simultaneous IF and MEM requests:
  - MEM ready at cycle WAIT_CYCLES+1;
  - IF granted at cycle WAIT_CYCLES+2;
  - IF ready at cycle 2·WAIT_CYCLES+3, when `freeze` drops;
  - both ready flags are high together in that final cycle.
- A request arriving during ACCESS or RECOVER waits for IDLE.
- `rst` mid-access: all state returns to reset values on that edge and the in-flight access is abandoned; `sram_we` is 0 in the next cycle.
- Counter wrap is impossible: the counter is reloaded on every grant.

## Configuration
- `ARB_PERF_CNT_EN` defined: `freeze_cycles` increments on each edge with `freeze=1` and `rst=0`, saturating at 0xFFFFFFFF.
- `ARB_PERF_CNT_EN` undefined: `freeze_cycles` is constant 0 and no counter logic is synthesized.

## Test plan
- Reset then idle, WAIT_CYCLES=4: all outputs 0 and `freeze=0` for 10 cycles.
- IF-only read, `if_addr=0x10`, SRAM word 4 = 0x8C010004:
  - `sram_addr=4`, `sram_en=1` in cycles 1–4;
  - `if_ready=1`, `if_rdata=0x8C010004` and `freeze=0` in cycle 5.
- MEM store plus IF fetch in the same cycle, `mem_addr=0x20`, `mem_wdata=0xDEADBEEF`:
  - `sram_we=1`, `sram_addr=8` in cycles 1–4;
  - IF access in cycles 7–10;
  - `freeze` high in cycles 0–10 and low in cycle 11;
  - a later read of 0x20 returns 0xDEADBEEF.
- Served flags: hold `if_req` with `mem_r_en` pending behind it and check that IF is not accessed twice. Exactly two SRAM grants occur per frozen interval.
- Reset asserted in cycle 2 of a store: `sram_we=0` from cycle 3; no ready is asserted; a new request completes normally afterwards.
- Performance counter, with `ARB_PERF_CNT_EN` defined: three single IF fetches give `freeze_cycles=15`; without the macro it reads 0.
